md5_block_ctrl: RTL
===================

MD5_BLOCK_CTRL -- requirements
Module: md5_block_ctrl

Interface
Parameters: none; the round count is fixed at 64.
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  request to hash one block; sampled only when ready=1.
REQ-005 block  in  512  message words M[j]=block[32j+31:32j], j=0..15.
REQ-006 h_in  in  128  chaining value: A=[31:0], B=[63:32], C=[95:64], D=[127:96].
REQ-007 ready  out  1  high in IDLE.
REQ-008 done  out  1  one-cycle pulse when h_out is updated.
REQ-009 h_out  out  128  result, same word packing as h_in; held until the next done.
REQ-010 rnd_valid  out  1  high while round operands are live (RUN).
REQ-011 rnd_a, rnd_b, rnd_c, rnd_d  out  32 each  working registers presented to the round stage.
REQ-012 rnd_m  out  32  message word M[g] for the current round.
REQ-013 rnd_s  out  5  rotate amount.
REQ-014 rnd_t  out  32  additive constant K[i].
REQ-015 rnd_r  out  2  function select: 0=F, 1=G, 2=H, 3=I.
REQ-016 rnd_next_a  in  32  combinational result returned by the round stage.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FINAL, with a 6-bit round counter i.
REQ-018 IDLE + start SHALL trigger the following:
- latch block and h_in;
- load a..d from A..D;
- set i=0;
- go to RUN.
REQ-019 start in RUN or FINAL SHALL be ignored and SHALL NOT be queued.
REQ-020 On each RUN edge, the registers SHALL update as a<=d, b<=rnd_next_a, c<=b, d<=c, i<=i+1.
REQ-021 When i=63, the RUN edge SHALL perform the REQ-020 update and go to FINAL.
REQ-022 The FINAL edge SHALL set:
- h_out words to {A+a, B+b, C+c, D+d}, each sum mod 2^32 (carries discarded, no cross-word carry);
- done<=1;
- state to IDLE.
REQ-023 done SHALL be high for exactly one cycle; ready SHALL be 1 in that same cycle, so a start there is accepted (back-to-back blocks).
REQ-024 Latency: start sampled at edge E0 -> done high in the cycle after edge E65 (64 round edges plus 1 final edge).
REQ-025 The round operands SHALL be combinational from the registers and i:
- rnd_r = i[5:4];
- g = i (r=0), (5i+1) mod 16 (r=1), (3i+5) mod 16 (r=2), 7i mod 16 (r=3);
- rnd_m = M[g].
REQ-026 rnd_s SHALL be indexed by i[1:0] within each round group:
- r=0: {7,12,17,22};
- r=1: {5,9,14,20};
- r=2: {4,11,16,23};
- r=3: {6,10,15,21}.
REQ-027 rnd_t = K[i] SHALL use the 64-entry RFC 1321 table (floor(|sin(i+1)|*2^32)), hardwired.
REQ-028 rnd_valid SHALL be 1 only in RUN; in all other states the rnd_* outputs are don't-care to consumers but remain deterministic per REQ-025..027.

Reset
REQ-029 rst SHALL take priority over start and over every state, including mid-RUN and FINAL.
REQ-030 After a reset edge the block SHALL be in this state:
- state=IDLE, ready=1, done=0, rnd_valid=0;
- h_out=0;
- i=0, and a..d, latched block and latched H all 0.
REQ-031 Following from REQ-030, the operand outputs after reset SHALL read:
- rnd_a..rnd_d=0;
- rnd_m=0;
- rnd_r=0;
- rnd_s=7;
- rnd_t=0xd76aa478.
REQ-032 A reset during RUN SHALL abandon the block: done is not asserted and h_out keeps its reset value 0.

Verification
REQ-033 Reset check: assert rst for 2 cycles -> ready=1, done=0, h_out=0, rnd_s=7, rnd_t=0xd76aa478.
REQ-034 Empty-string MD5, with a correct md5round connected:
- stimulus: M[0]=0x00000080, other words 0, h_in A..D=0x67452301, 0xefcdab89, 0x98badcfe, 0x10325476;
- response: done exactly 65 cycles after start, h_out A..D=0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec.
REQ-035 Schedule spot checks during RUN:
- i=17 -> rnd_r=1, rnd_m=M[6], rnd_s=9, rnd_t=0xc040b340;
- i=35 -> rnd_r=2, rnd_m=M[14], rnd_s=23, rnd_t=0xfde5380c.
REQ-036 start pulsed at RUN round 10 -> ignored; exactly one done, 65 cycles after the original start.
REQ-037 start held high continuously -> second block accepted in the done cycle; the next done follows 65 cycles later; h_out is correct for both.
REQ-038 rst at round 30 -> IDLE on the next cycle, no done, h_out=0; a fresh start then reproduces the REQ-034 result.

Source files
------------

// File: rtl/md5_block_ctrl.sv
// MD5 single-block controller: sequences 64 rounds through an external round
// stage and folds the working registers back into the chaining value.
module md5_block_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block,
  input  logic [127:0] h_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] h_out,
  output logic         rnd_valid,
  output logic [31:0]  rnd_a,
  output logic [31:0]  rnd_b,
  output logic [31:0]  rnd_c,
  output logic [31:0]  rnd_d,
  output logic [31:0]  rnd_m,
  output logic [4:0]   rnd_s,
  output logic [31:0]  rnd_t,
  output logic [1:0]   rnd_r,
  input  logic [31:0]  rnd_next_a
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t        state_q, state_d;
  logic [5:0]    i_q, i_d;
  logic [31:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [511:0]  blk_q, blk_d;
  logic [127:0]  h_q, h_d;
  logic [127:0]  h_out_q, h_out_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          vld_q, vld_d;
  logic [3:0]    g;

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    case (idx)
      6'd0:  k_const = 32'hd76aa478; 6'd1:  k_const = 32'he8c7b756;
      6'd2:  k_const = 32'h242070db; 6'd3:  k_const = 32'hc1bdceee;
      6'd4:  k_const = 32'hf57c0faf; 6'd5:  k_const = 32'h4787c62a;
      6'd6:  k_const = 32'ha8304613; 6'd7:  k_const = 32'hfd469501;
      6'd8:  k_const = 32'h698098d8; 6'd9:  k_const = 32'h8b44f7af;
      6'd10: k_const = 32'hffff5bb1; 6'd11: k_const = 32'h895cd7be;
      6'd12: k_const = 32'h6b901122; 6'd13: k_const = 32'hfd987193;
      6'd14: k_const = 32'ha679438e; 6'd15: k_const = 32'h49b40821;
      6'd16: k_const = 32'hf61e2562; 6'd17: k_const = 32'hc040b340;
      6'd18: k_const = 32'h265e5a51; 6'd19: k_const = 32'he9b6c7aa;
      6'd20: k_const = 32'hd62f105d; 6'd21: k_const = 32'h02441453;
      6'd22: k_const = 32'hd8a1e681; 6'd23: k_const = 32'he7d3fbc8;
      6'd24: k_const = 32'h21e1cde6; 6'd25: k_const = 32'hc33707d6;
      6'd26: k_const = 32'hf4d50d87; 6'd27: k_const = 32'h455a14ed;
      6'd28: k_const = 32'ha9e3e905; 6'd29: k_const = 32'hfcefa3f8;
      6'd30: k_const = 32'h676f02d9; 6'd31: k_const = 32'h8d2a4c8a;
      6'd32: k_const = 32'hfffa3942; 6'd33: k_const = 32'h8771f681;
      6'd34: k_const = 32'h6d9d6122; 6'd35: k_const = 32'hfde5380c;
      6'd36: k_const = 32'ha4beea44; 6'd37: k_const = 32'h4bdecfa9;
      6'd38: k_const = 32'hf6bb4b60; 6'd39: k_const = 32'hbebfbc70;
      6'd40: k_const = 32'h289b7ec6; 6'd41: k_const = 32'heaa127fa;
      6'd42: k_const = 32'hd4ef3085; 6'd43: k_const = 32'h04881d05;
      6'd44: k_const = 32'hd9d4d039; 6'd45: k_const = 32'he6db99e5;
      6'd46: k_const = 32'h1fa27cf8; 6'd47: k_const = 32'hc4ac5665;
      6'd48: k_const = 32'hf4292244; 6'd49: k_const = 32'h432aff97;
      6'd50: k_const = 32'hab9423a7; 6'd51: k_const = 32'hfc93a039;
      6'd52: k_const = 32'h655b59c3; 6'd53: k_const = 32'h8f0ccc92;
      6'd54: k_const = 32'hffeff47d; 6'd55: k_const = 32'h85845dd1;
      6'd56: k_const = 32'h6fa87e4f; 6'd57: k_const = 32'hfe2ce6e0;
      6'd58: k_const = 32'ha3014314; 6'd59: k_const = 32'h4e0811a1;
      6'd60: k_const = 32'hf7537e82; 6'd61: k_const = 32'hbd3af235;
      6'd62: k_const = 32'h2ad7d2bb; default: k_const = 32'heb86d391;
    endcase
  endfunction

  function automatic logic [4:0] s_const(input logic [1:0] r, input logic [1:0] j);
    case ({r, j})
      4'h0: s_const = 5'd7;  4'h1: s_const = 5'd12; 4'h2: s_const = 5'd17; 4'h3: s_const = 5'd22;
      4'h4: s_const = 5'd5;  4'h5: s_const = 5'd9;  4'h6: s_const = 5'd14; 4'h7: s_const = 5'd20;
      4'h8: s_const = 5'd4;  4'h9: s_const = 5'd11; 4'ha: s_const = 5'd16; 4'hb: s_const = 5'd23;
      4'hc: s_const = 5'd6;  4'hd: s_const = 5'd10; 4'he: s_const = 5'd15; default: s_const = 5'd21;
    endcase
  endfunction

  // Message schedule: only i mod 16 matters, so 4-bit arithmetic wraps correctly.
  always_comb begin
    case (i_q[5:4])
      2'd0:    g = i_q[3:0];
      2'd1:    g = i_q[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i_q[3:0] * 4'd3 + 4'd5;
      default: g = i_q[3:0] * 4'd7;
    endcase
  end

  assign rnd_r     = i_q[5:4];
  assign rnd_m     = blk_q[{g, 5'd0} +: 32];
  assign rnd_s     = s_const(i_q[5:4], i_q[1:0]);
  assign rnd_t     = k_const(i_q);
  assign rnd_a     = a_q;
  assign rnd_b     = b_q;
  assign rnd_c     = c_q;
  assign rnd_d     = d_q;
  assign rnd_valid = vld_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign h_out     = h_out_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    blk_d   = blk_q;
    h_d     = h_q;
    h_out_d = h_out_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = block;
          h_d     = h_in;
          a_d     = h_in[31:0];
          b_d     = h_in[63:32];
          c_d     = h_in[95:64];
          d_d     = h_in[127:96];
          i_d     = 6'd0;
          state_d = RUN;
          ready_d = 1'b0;
          vld_d   = 1'b1;
        end
      end
      RUN: begin
        a_d = d_q;
        b_d = rnd_next_a;
        c_d = b_q;
        d_d = c_q;
        i_d = i_q + 6'd1;
        if (i_q == 6'd63) begin
          state_d = FINAL;
          vld_d   = 1'b0;
        end
      end
      default: begin
        // Per-word adds; carries never cross a 32-bit boundary.
        h_out_d = {h_q[127:96] + d_q, h_q[95:64] + c_q,
                   h_q[63:32] + b_q, h_q[31:0] + a_q};
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      d_q     <= 32'd0;
      blk_q   <= 512'd0;
      h_q     <= 128'd0;
      h_out_q <= 128'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      blk_q   <= blk_d;
      h_q     <= h_d;
      h_out_q <= h_out_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
    end
  end

endmodule
